// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller around a registered-output dual-port RAM
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   winc, wdata           push request and data
//   rinc                  pop request
//   rdata, rvalid         RAM output register and its one-cycle valid flag
//   wfull, rempty         full/empty flags decoded from the pointer pair
//   almost_full/empty     level threshold flags
//   level                 occupancy 0..DEPTH
//   wr_err, rd_err        one-cycle pulses for a push while full / pop while empty

module dual_port_RAM #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     wclk,
  input  logic                     wenc,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rclk,
  input  logic                     renc,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge wclk)
    if (wenc) r_mem[waddr] <= wdata;
  always_ff @(posedge rclk)
    if (renc) rdata <= r_mem[raddr];
endmodule

module sync_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     winc,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rinc,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     wfull,
  output logic                     rempty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     wr_err,
  output logic                     rd_err
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  logic        r_rvalid, r_wr_err, r_rd_err;
  logic        w_wen, w_ren;
  // Extra MSB is the wrap bit: equal addresses with differing wrap bits means full.
  assign rempty       = r_wptr == r_rptr;
  assign wfull        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level        = r_wptr - r_rptr;
  assign almost_full  = level >= (AW+1)'(AF_LEVEL);
  assign almost_empty = level <= (AW+1)'(AE_LEVEL);
  assign w_wen        = winc & ~wfull;
  assign w_ren        = rinc & ~rempty;
  assign rvalid       = r_rvalid;
  assign wr_err       = r_wr_err;
  assign rd_err       = r_rd_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rvalid <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wptr   <= r_wptr + (AW+1)'(w_wen);
      r_rptr   <= r_rptr + (AW+1)'(w_ren);
      r_rvalid <= w_ren;
      r_wr_err <= winc & wfull;
      r_rd_err <= rinc & rempty;
    end
  dual_port_RAM #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .wclk  (clk),
    .wenc  (w_wen),
    .waddr (r_wptr[AW-1:0]),
    .wdata (wdata),
    .rclk  (clk),
    .renc  (w_ren),
    .raddr (r_rptr[AW-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       rvalid, wfull, rempty, almost_full, almost_empty, wr_err, rd_err;
  logic [4:0] level;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({rempty, wfull, level, almost_empty, almost_full, rvalid, wr_err, rd_err} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got e%b f%b lvl%0d ae%b af%b rv%b we%b re%b exp e1 f0 lvl0 ae1 af0 rv0 we0 re0",
               rempty, wfull, level, almost_empty, almost_full, rvalid, wr_err, rd_err);
    end
    step();
    checks++;
    if ({rvalid, wr_err, rd_err, level} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_idle got rv%b we%b re%b lvl%0d exp rv0 we0 re0 lvl0", rvalid, wr_err, rd_err, level);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      wdata = 8'(i);
      step();
      checks++;
      if ({level, almost_full, wfull, rempty, wr_err} !== {5'(i + 1), i + 1 >= 14, i == 15, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL fill_%0d got lvl%0d af%b f%b e%b we%b exp lvl%0d af%b f%b e0 we0",
                 i, level, almost_full, wfull, rempty, wr_err, i + 1, i + 1 >= 14, i == 15);
      end
    end
    wdata = 8'hAA;
    step();
    checks++;
    if ({wr_err, level, wfull} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL overflow got we%b lvl%0d f%b exp we1 lvl16 f1", wr_err, level, wfull);
    end
    winc = 1'b0;
    step();
    checks++;
    if ({wr_err, level} !== {1'b0, 5'd16}) begin
      errors++;
      $display("FAIL overflow_pulse got we%b lvl%0d exp we0 lvl16", wr_err, level);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rinc = 1'b1;
      step();
      checks++;
      if ({rvalid, rdata, level, rempty} !== {1'b1, 8'(i), 5'(15 - i), i == 15}) begin
        errors++;
        $display("FAIL drain_%0d got rv%b d%h lvl%0d e%b exp rv1 d%h lvl%0d e%b",
                 i, rvalid, rdata, level, rempty, 8'(i), 15 - i, i == 15);
      end
    end
    step();
    checks++;
    if ({rd_err, rvalid, level, rempty} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow got re%b rv%b lvl%0d e%b exp re1 rv0 lvl0 e1", rd_err, rvalid, level, rempty);
    end
    rinc = 1'b0;
    step();
    checks++;
    if ({rd_err, rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL underflow_pulse got re%b rv%b exp re0 rv0", rd_err, rvalid);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1;
      wdata = 8'(8'h40 + i);
      step();
    end
    checks++;
    if ({level, almost_empty} !== {5'd3, 1'b0}) begin
      errors++;
      $display("FAIL wrap_prime got lvl%0d ae%b exp lvl3 ae0", level, almost_empty);
    end
    for (int j = 0; j < 40; j++) begin
      winc = 1'b1;
      rinc = 1'b1;
      wdata = 8'(8'h43 + j);
      step();
      checks++;
      if ({rvalid, rdata, level, wfull} !== {1'b1, 8'(8'h40 + j), 5'd3, 1'b0}) begin
        errors++;
        $display("FAIL wrap_%0d got rv%b d%h lvl%0d f%b exp rv1 d%h lvl3 f0",
                 j, rvalid, rdata, level, wfull, 8'(8'h40 + j));
      end
    end
    winc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({rvalid, rdata, level} !== {1'b1, 8'(8'h68 + k), 5'(2 - k)}) begin
        errors++;
        $display("FAIL wrap_tail_%0d got rv%b d%h lvl%0d exp rv1 d%h lvl%0d",
                 k, rvalid, rdata, level, 8'(8'h68 + k), 2 - k);
      end
    end
    rinc = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      wdata = 8'(i);
      step();
    end
    wdata = 8'h77;
    rinc = 1'b1;
    step();
    checks++;
    if ({rvalid, rdata, wr_err, rd_err, level} !== {1'b1, 8'h00, 1'b1, 1'b0, 5'd15}) begin
      errors++;
      $display("FAIL full_both got rv%b d%h we%b re%b lvl%0d exp rv1 d00 we1 re0 lvl15",
               rvalid, rdata, wr_err, rd_err, level);
    end
    winc = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      checks++;
      if ({rvalid, rdata} !== {1'b1, 8'(i)}) begin
        errors++;
        $display("FAIL full_drain_%0d got rv%b d%h exp rv1 d%h", i, rvalid, rdata, 8'(i));
      end
    end
    winc = 1'b1;
    wdata = 8'h5A;
    step();
    checks++;
    if ({rd_err, wr_err, rvalid, level} !== {1'b1, 1'b0, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL empty_both got re%b we%b rv%b lvl%0d exp re1 we0 rv0 lvl1", rd_err, wr_err, rvalid, level);
    end
    winc = 1'b0;
    step();
    checks++;
    if ({rvalid, rdata, level, rd_err} !== {1'b1, 8'h5A, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL empty_both_read got rv%b d%h lvl%0d re%b exp rv1 d5a lvl0 re0", rvalid, rdata, level, rd_err);
    end
    rinc = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      winc = 1'b1;
      wdata = 8'(8'h10 + i);
      step();
    end
    winc = 1'b0;
    checks++;
    if (level !== 5'd9) begin
      errors++;
      $display("FAIL pre_reset_level got %0d exp 9", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rempty, wfull, level, almost_empty, almost_full} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got e%b f%b lvl%0d ae%b af%b exp e1 f0 lvl0 ae1 af0",
               rempty, wfull, level, almost_empty, almost_full);
    end
    step();
    rst_n = 1'b1;
    step();
    winc = 1'b1;
    wdata = 8'h33;
    step();
    winc = 1'b0;
    rinc = 1'b1;
    step();
    checks++;
    if ({rvalid, rdata, level, rempty} !== {1'b1, 8'h33, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_read got rv%b d%h lvl%0d e%b exp rv1 d33 lvl0 e1", rvalid, rdata, level, rempty);
    end
    step();
    checks++;
    if ({rvalid, rd_err} !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_stale got rv%b re%b exp rv0 re1", rvalid, rd_err);
    end
    rinc = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
